// File: rtl/instr_retire_monitor.sv
// rtl/instr_retire_monitor.sv - retire-stream classifier with saturating class counters and a cycle-stamped PC trace FIFO
module instr_retire_monitor #(
    parameter int PC_W  = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     retire_valid,
    input  logic [PC_W-1:0]          retire_pc,
    input  logic [31:0]              retire_instr,
    input  logic                     trace_en,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [PC_W-1:0]          rd_pc,
    output logic [4:0]               rd_class,
    output logic [CNT_W-1:0]         rd_cycle,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [CNT_W-1:0]         drop_cnt,
    input  logic [4:0]               cnt_sel,
    output logic [CNT_W-1:0]         cnt_value,
    input  logic                     cnt_clear
);
    localparam int AW   = $clog2(DEPTH);
    localparam int NCLS = 17;

    logic [4:0]       cls;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] cnt_q [NCLS];
    logic [CNT_W-1:0] cnt_d [NCLS];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PC_W-1:0]  mem_pc   [DEPTH];
    logic [4:0]       mem_cls  [DEPTH];
    logic [CNT_W-1:0] mem_cyc  [DEPTH];
    logic             push_req, push, pop, full, drop;

    always_comb begin
        cls = 5'd16;
        if (retire_instr[31:26] == 6'd0) begin
            case (retire_instr[5:0])
                6'd32: cls = 5'd0;
                6'd34: cls = 5'd1;
                6'd36: cls = 5'd2;
                6'd37: cls = 5'd3;
                6'd8:  cls = 5'd4;
                6'd42: cls = 5'd5;
                6'd27: cls = 5'd6;
                6'd16: cls = 5'd7;
                6'd18: cls = 5'd8;
                6'd2:  cls = 5'd9;
                6'd0:  cls = 5'd10;
                default: cls = 5'd16;
            endcase
        end else begin
            case (retire_instr[31:26])
                6'd13: cls = 5'd11;
                6'd35: cls = 5'd12;
                6'd43: cls = 5'd13;
                6'd4:  cls = 5'd14;
                6'd2:  cls = 5'd15;
                default: cls = 5'd16;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        push_req = retire_valid & trace_en;
        full     = (level_q == (AW+1)'(DEPTH));
        pop      = rd_en & (level_q != '0);
        push     = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    always_comb begin
        cycle_d  = cycle_q + CNT_W'(1);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      level_d = level_q + (AW+1)'(1);
        else if (pop && !push) level_d = level_q - (AW+1)'(1);
    end

    // Clear acts first, so a same-cycle event lands on zeroed state.
    always_comb begin
        ovf_d  = cnt_clear ? 1'b0 : ovf_q;
        drop_d = cnt_clear ? '0 : drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_d != '1) drop_d = drop_d + CNT_W'(1);
        end
        for (int i = 0; i < NCLS; i++) begin
            cnt_d[i] = cnt_clear ? '0 : cnt_q[i];
            if (retire_valid && cls == 5'(i) && cnt_d[i] != '1)
                cnt_d[i] = cnt_d[i] + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
            for (int i = 0; i < NCLS; i++) cnt_q[i] <= '0;
        end else begin
            cycle_q  <= cycle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
            for (int i = 0; i < NCLS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr_q]  <= retire_pc;
            mem_cls[wr_ptr_q] <= cls;
            mem_cyc[wr_ptr_q] <= cycle_q;
        end
    end

    always_comb begin
        rd_valid   = (level_q != '0);
        rd_pc      = rd_valid ? mem_pc[rd_ptr_q]  : '0;
        rd_class   = rd_valid ? mem_cls[rd_ptr_q] : '0;
        rd_cycle   = rd_valid ? mem_cyc[rd_ptr_q] : '0;
        fifo_level = level_q;
        overflow   = ovf_q;
        drop_cnt   = drop_q;
        cnt_value  = (cnt_sel < 5'(NCLS)) ? cnt_q[cnt_sel] : '0;
    end
endmodule
